// File: rtl/dmem_dual_port_arbiter.sv
// Two-lane load/store front end for a 1R/1W data memory: stores post to a write buffer, loads serialise on the read port.
// Load data returns 1 cycle after accept; ready is combinational and lane 1 never passes a stalled lane 0.
module dmem_dual_port_arbiter #(
   parameter int WB_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        l0_req,
   input  logic        l0_we,
   input  logic [31:0] l0_addr,
   input  logic [31:0] l0_wdata,
   output logic        l0_ready,
   output logic        l0_rvalid,
   output logic [31:0] l0_rdata,
   input  logic        l1_req,
   input  logic        l1_we,
   input  logic [31:0] l1_addr,
   input  logic [31:0] l1_wdata,
   output logic        l1_ready,
   output logic        l1_rvalid,
   output logic [31:0] l1_rdata,
   output logic [31:0] mem_raddress,
   input  logic [31:0] mem_rdata,
   output logic        mem_write,
   output logic [31:0] mem_waddress,
   output logic [31:0] mem_wdata
);
   localparam int AW = $clog2(WB_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(WB_DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wb_ent_t;

   wb_ent_t       wb_q [WB_DEPTH];
   wb_ent_t       wb_d [WB_DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [AW-1:0] l1_slot;
   logic [AW-1:0] idx;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   raddr_q;
   logic [31:0]   l0_rdata_q, l0_rdata_d;
   logic [31:0]   l1_rdata_q, l1_rdata_d;
   logic          l0_rvalid_q, l1_rvalid_q;
   logic          l0_st, l0_ld, l1_st, l1_ld;
   logic          ld_vld, pop, fwd_hit;
   logic [31:0]   ld_addr, fwd_data, ld_data;

   // Acceptance looks only at start-of-cycle occupancy, so a same-cycle drain frees nothing.
   always_comb begin
      l0_ready = l0_we ? (count_q < DEPTH_C) : 1'b1;
      l0_st    = l0_req & l0_ready & l0_we;
      l0_ld    = l0_req & l0_ready & ~l0_we;
      l1_ready = (~l0_req | l0_ready) &
                 (l1_we ? ((count_q + CW'(l0_st)) < DEPTH_C) : ~(l0_req & ~l0_we));
      l1_st    = l1_req & l1_ready & l1_we;
      l1_ld    = l1_req & l1_ready & ~l1_we;
   end

   // Scan oldest to youngest so the entry nearest tail overrides; a same-cycle lane 0 store is younger still.
   always_comb begin
      ld_vld   = l0_ld | l1_ld;
      ld_addr  = l0_ld ? l0_addr : l1_addr;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = head_q;
      for (int i = 0; i < WB_DEPTH; i++) begin
         idx = head_q + AW'(i);
         if ((CW'(i) < count_q) && (wb_q[idx].addr[31:2] == ld_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_q[idx].data;
         end
      end
      if (l1_ld && l0_st && (l0_addr[31:2] == l1_addr[31:2])) begin
         fwd_hit  = 1'b1;
         fwd_data = l0_wdata;
      end
      ld_data      = fwd_hit ? fwd_data : mem_rdata;
      mem_raddress = ld_vld ? ld_addr : raddr_q;
      l0_rdata_d   = l0_ld ? ld_data : l0_rdata_q;
      l1_rdata_d   = l1_ld ? ld_data : l1_rdata_q;
   end

   always_comb begin
      wb_d    = wb_q;
      pop     = (count_q != '0);
      l1_slot = tail_q + AW'(l0_st);
      if (l0_st) begin
         wb_d[tail_q] = '{addr: l0_addr, data: l0_wdata};
      end
      if (l1_st) begin
         wb_d[l1_slot] = '{addr: l1_addr, data: l1_wdata};
      end
      tail_d  = l1_slot + AW'(l1_st);
      head_d  = head_q + AW'(pop);
      count_d = count_q + CW'(l0_st) + CW'(l1_st) - CW'(pop);
   end

   // Entry payloads need no reset: nothing reads them while count is zero.
   always_ff @(posedge clk) begin
      wb_q <= wb_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         raddr_q     <= '0;
         l0_rvalid_q <= 1'b0;
         l1_rvalid_q <= 1'b0;
         l0_rdata_q  <= '0;
         l1_rdata_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         raddr_q     <= mem_raddress;
         l0_rvalid_q <= l0_ld;
         l1_rvalid_q <= l1_ld;
         l0_rdata_q  <= l0_rdata_d;
         l1_rdata_q  <= l1_rdata_d;
      end
   end

   assign mem_write    = pop;
   assign mem_waddress = wb_q[head_q].addr;
   assign mem_wdata    = wb_q[head_q].data;
   assign l0_rvalid    = l0_rvalid_q;
   assign l1_rvalid    = l1_rvalid_q;
   assign l0_rdata     = l0_rdata_q;
   assign l1_rdata     = l1_rdata_q;

endmodule

// File: tb/tb_dmem_dual_port_arbiter.sv
// Scoreboard bench: program-order shadow memory predicts load data and drains; a negedge monitor checks DUT outputs.
// Stimulus is directed scenarios followed by randomized two-lane traffic over a small address window.
module tb_dmem_dual_port_arbiter;
   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        l0_req, l0_we, l1_req, l1_we;
   logic [31:0] l0_addr, l0_wdata, l1_addr, l1_wdata;
   logic        l0_ready, l0_rvalid, l1_ready, l1_rvalid;
   logic [31:0] l0_rdata, l1_rdata;
   logic [31:0] mem_raddress, mem_rdata, mem_waddress, mem_wdata;
   logic        mem_write;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int occ = 0;

   typedef struct { logic [31:0] data; int cyc; } ld_exp_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } st_exp_t;

   ld_exp_t q0[$];
   ld_exp_t q1[$];
   st_exp_t sq[$];

   logic [31:0] tbmem  [256];
   logic [31:0] shadow [256];

   dmem_dual_port_arbiter #(.WB_DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .l0_req(l0_req), .l0_we(l0_we), .l0_addr(l0_addr), .l0_wdata(l0_wdata),
      .l0_ready(l0_ready), .l0_rvalid(l0_rvalid), .l0_rdata(l0_rdata),
      .l1_req(l1_req), .l1_we(l1_we), .l1_addr(l1_addr), .l1_wdata(l1_wdata),
      .l1_ready(l1_ready), .l1_rvalid(l1_rvalid), .l1_rdata(l1_rdata),
      .mem_raddress(mem_raddress), .mem_rdata(mem_rdata), .mem_write(mem_write),
      .mem_waddress(mem_waddress), .mem_wdata(mem_wdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = tbmem[mem_raddress[9:2]];
   always @(posedge clk) if (!rst && mem_write) tbmem[mem_waddress[9:2]] <= mem_wdata;

   function automatic logic [31:0] init_pat(input int i);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents load data or a drain.
   always @(negedge clk) begin : monitor
      ld_exp_t e;
      st_exp_t s;
      if (!rst) begin
         if (l0_rvalid) begin
            if (q0.size() == 0) check32("l0_rvalid_spurious", {31'b0, l0_rvalid}, 32'd0);
            else begin
               e = q0.pop_front();
               check32("l0_rdata", l0_rdata, e.data);
               check32("l0_rvalid_cycle", 32'(cyc), 32'(e.cyc + 1));
            end
         end else if (q0.size() != 0 && q0[0].cyc < cyc) begin
            e = q0.pop_front();
            check32("l0_rvalid_missing", {31'b0, l0_rvalid}, 32'd1);
         end
         if (l1_rvalid) begin
            if (q1.size() == 0) check32("l1_rvalid_spurious", {31'b0, l1_rvalid}, 32'd0);
            else begin
               e = q1.pop_front();
               check32("l1_rdata", l1_rdata, e.data);
               check32("l1_rvalid_cycle", 32'(cyc), 32'(e.cyc + 1));
            end
         end else if (q1.size() != 0 && q1[0].cyc < cyc) begin
            e = q1.pop_front();
            check32("l1_rvalid_missing", {31'b0, l1_rvalid}, 32'd1);
         end
         if (mem_write) begin
            if (sq.size() == 0) check32("mem_write_spurious", {31'b0, mem_write}, 32'd0);
            else begin
               s = sq.pop_front();
               check32("mem_waddress", mem_waddress, s.addr);
               check32("mem_wdata", mem_wdata, s.data);
               check32("drain_after_accept", 32'(s.cyc < cyc), 32'd1);
            end
         end else if (sq.size() != 0 && sq[0].cyc < cyc) begin
            s = sq.pop_front();
            check32("mem_write_missing", {31'b0, mem_write}, 32'd1);
         end
      end
   end

   task automatic drive_idle();
      l0_req = 0; l0_we = 0; l0_addr = 0; l0_wdata = 0;
      l1_req = 0; l1_we = 0; l1_addr = 0; l1_wdata = 0;
   endtask

   // One cycle of requests; the model applies the accept rules and program-order memory semantics.
   task automatic cyc_op(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
      bit er0, er1, st0, st1, ld0, ld1;
      @(posedge clk);
      #1;
      l0_req = r0; l0_we = w0; l0_addr = a0; l0_wdata = d0;
      l1_req = r1; l1_we = w1; l1_addr = a1; l1_wdata = d1;
      @(negedge clk);
      er0 = w0 ? (occ < D) : 1'b1;
      st0 = r0 & er0 & w0;
      ld0 = r0 & er0 & !w0;
      er1 = (!r0 || er0) && (w1 ? (occ + int'(st0) < D) : !(r0 && !w0));
      st1 = r1 & er1 & w1;
      ld1 = r1 & er1 & !w1;
      if (r0) check32("l0_ready", {31'b0, l0_ready}, {31'b0, er0});
      if (r1) check32("l1_ready", {31'b0, l1_ready}, {31'b0, er1});
      if (ld0) begin
         check32("mem_raddress_l0", mem_raddress, a0);
         q0.push_back('{shadow[a0[9:2]], cyc});
      end
      if (st0) begin
         shadow[a0[9:2]] = d0;
         sq.push_back('{a0, d0, cyc});
      end
      if (ld1) begin
         check32("mem_raddress_l1", mem_raddress, a1);
         q1.push_back('{shadow[a1[9:2]], cyc});
      end
      if (st1) begin
         shadow[a1[9:2]] = d1;
         sq.push_back('{a1, d1, cyc});
      end
      occ = occ + int'(st0) + int'(st1) - ((occ > 0) ? 1 : 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_op(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_idle();
      #1;
      check32("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check32("rst_l0_rvalid", {31'b0, l0_rvalid}, 32'd0);
      check32("rst_l1_rvalid", {31'b0, l1_rvalid}, 32'd0);
      check32("rst_l0_rdata", l0_rdata, 32'd0);
      check32("rst_l1_rdata", l1_rdata, 32'd0);
      repeat (2) @(negedge clk);
      q0.delete(); q1.delete(); sq.delete();
      occ = 0;
      for (int i = 0; i < 256; i++) shadow[i] = tbmem[i];
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) tbmem[i] = init_pat(i);
      tbmem[16] = 32'hA5;
      drive_idle();
      do_reset();

      // Plain load with memory data, then forwarding from a same-cycle lane 0 store.
      cyc_op(1, 0, 32'h40, 0, 0, 0, 0, 0);
      cyc_op(1, 1, 32'h80, 32'h11, 1, 0, 32'h80, 0);
      idle(2);

      // Three stores then a load before drain: youngest buffered entry wins.
      cyc_op(1, 1, 32'h100, 32'd1, 1, 1, 32'h104, 32'd2);
      cyc_op(1, 1, 32'h100, 32'd3, 0, 0, 0, 0);
      cyc_op(1, 0, 32'h100, 0, 0, 0, 0, 0);
      idle(5);
      check32("mem_0x100", tbmem[32'h100 >> 2], 32'd3);
      check32("mem_0x104", tbmem[32'h104 >> 2], 32'd2);

      // Back-to-back dual stores push occupancy to its ceiling.
      for (int i = 0; i < 5; i++)
         cyc_op(1, 1, 32'h300 + 32'(8 * i), $urandom, 1, 1, 32'h304 + 32'(8 * i), $urandom);
      cyc_op(1, 1, 32'h380, 32'h55, 1, 0, 32'h300, 0);
      idle(6);

      // Dual loads serialise on the single read port.
      cyc_op(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
      cyc_op(0, 0, 0, 0, 1, 0, 32'h4, 0);
      idle(2);

      // Reset with buffered stores: they must never reach memory.
      cyc_op(1, 1, 32'h200, 32'hAAAA, 1, 1, 32'h204, 32'hBBBB);
      cyc_op(1, 1, 32'h208, 32'hCCCC, 1, 1, 32'h20C, 32'hDDDD);
      @(posedge clk);
      #1;
      check32("pre_reset_mem_write", {31'b0, mem_write}, {31'b0, occ > 0});
      do_reset();
      idle(6);
      check32("discarded_0x208", tbmem[32'h208 >> 2], init_pat(32'h208 >> 2));
      check32("discarded_0x20C", tbmem[32'h20C >> 2], init_pat(32'h20C >> 2));

      // Randomized traffic over a 16-word window to exercise forwarding.
      for (int i = 0; i < 600; i++) begin
         cyc_op($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)), $urandom,
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3)), $urandom);
      end
      idle(10);

      check32("q0_drained", 32'(q0.size()), 32'd0);
      check32("q1_drained", 32'(q1.size()), 32'd0);
      check32("sq_drained", 32'(sq.size()), 32'd0);
      for (int i = 0; i < 256; i++) check32($sformatf("final_mem[%0d]", i), tbmem[i], shadow[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
